// File: rtl/spi_slave_if.sv
// Bus bundle between an SPI mode-0 slave and its host-side user.
// The slave modport is the block's view; the master modport is the host/bench view.
interface spi_slave_if #(
  parameter int WIDTH = 8
) ();
  logic             select_in;
  logic             sck_in;
  logic             mosi_in;
  logic             miso_out;
  logic [WIDTH-1:0] tx_data_in;
  logic             tx_load_in;
  logic             tx_ready_out;
  logic [WIDTH-1:0] rx_data_out;
  logic             rx_valid_out;
  logic             busy_out;
  logic             tx_underrun_out;

  modport slave (
    input  select_in, sck_in, mosi_in, tx_data_in, tx_load_in,
    output miso_out, tx_ready_out, rx_data_out, rx_valid_out, busy_out, tx_underrun_out
  );

  modport master (
    output select_in, sck_in, mosi_in, tx_data_in, tx_load_in,
    input  miso_out, tx_ready_out, rx_data_out, rx_valid_out, busy_out, tx_underrun_out
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by clk_in, with a one-word tx buffer.
// Optional sticky tx underrun flag is built only when SPI_SLAVE_UNDERRUN_EN is defined.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  spi_slave_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sel_sync, sck_sync, mosi_sync;
  logic                   sel_prev, sck_prev;
  logic                   sel_s, sck_s, mosi_s;
  logic                   sel_fall, sck_rise, sck_fall;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WIDTH-1:0]       tx_shift, rx_shift, rx_data, tx_buf;
  logic                   rx_valid, tx_full;
  logic                   entry, reload, shift_tx, shift_rx, abort;
  logic                   word_start, consume, accept;

  // Synchronizer stage: select presets high so reset reads as deselected
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sel_sync  <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      sel_prev  <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0],  bus.select_in};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  bus.sck_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_in};
      sel_prev  <= sel_sync[SYNC_STAGES-1];
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sel_fall = sel_prev & ~sel_s;
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    entry     = 1'b0;
    reload    = 1'b0;
    shift_tx  = 1'b0;
    shift_rx  = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_fall) begin
          state_nxt = S_ACTIVE;
          entry     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (sel_s) begin
          state_nxt = S_IDLE;
          abort     = 1'b1;
        end else begin
          shift_rx = sck_rise;
          if (sck_fall) begin
            reload   = (bit_cnt == '0);
            shift_tx = (bit_cnt != '0);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A word start pulls from the buffer; a load in the same cycle sees the pre-consume state
  assign word_start = entry | reload;
  assign consume    = word_start & tx_full;
  assign accept     = bus.tx_load_in & ~tx_full;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_full  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (word_start)
        tx_shift <= tx_full ? tx_buf : '0;
      else if (shift_tx)
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      if (shift_rx) begin
        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= {rx_shift[WIDTH-2:0], mosi_s};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (entry || abort) bit_cnt <= '0;
      if (consume) tx_full <= 1'b0;
      if (accept)  tx_full <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) tx_buf <= bus.tx_data_in;
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun;

  always_ff @(posedge clk_in) begin
    if (reset_in)                     underrun <= 1'b0;
    else if (word_start && !tx_full)  underrun <= 1'b1;
    else if (accept)                  underrun <= 1'b0;
  end

  assign bus.tx_underrun_out = underrun;
`else
  assign bus.tx_underrun_out = 1'b0;
`endif

  assign bus.miso_out     = (state == S_ACTIVE) & tx_shift[WIDTH-1];
  assign bus.tx_ready_out = ~tx_full;
  assign bus.rx_data_out  = rx_data;
  assign bus.rx_valid_out = rx_valid;
  assign bus.busy_out     = (state == S_ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// Directed plus randomized bench for spi_slave, acting as SPI master and tx host.
// Expected values come from a word-level model of the tx buffer and underrun flag.
module tb_spi_slave;
  localparam int W    = 8;
  localparam int HALF = 6;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  spi_slave_if #(.WIDTH(W)) bus ();

  spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  // Word-level model: buffer occupancy, buffered word, sticky underrun
  logic         m_full;
  logic [W-1:0] m_buf;
  logic         m_ur;

  // rx_valid monitor
  int           vld_pulses = 0;
  int           vld_cycles = 0;
  logic         vld_prev   = 1'b0;
  logic [W-1:0] rx_q[$];

  always @(negedge clk) begin
    if (bus.rx_valid_out === 1'b1) begin
      vld_cycles++;
      if (!vld_prev) begin
        vld_pulses++;
        rx_q.push_back(bus.rx_data_out);
      end
    end
    vld_prev = (bus.rx_valid_out === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] w);
    @(negedge clk);
    bus.tx_data_in = w;
    bus.tx_load_in = 1'b1;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = w;
      m_ur   = 1'b0;
    end
    @(negedge clk);
    bus.tx_load_in = 1'b0;
  endtask

  task automatic m_word_start(output logic [W-1:0] exp_miso);
    exp_miso = m_full ? m_buf : '0;
    if (!m_full) m_ur = 1'b1;
    m_full = 1'b0;
  endtask

  function automatic logic exp_ur();
`ifdef SPI_SLAVE_UNDERRUN_EN
    return m_ur;
`else
    return 1'b0;
`endif
  endfunction

  task automatic sel_low(output logic [W-1:0] exp_miso);
    @(negedge clk);
    bus.select_in = 1'b0;
    m_word_start(exp_miso);
  endtask

  task automatic sel_high();
    wait_cyc(HALF);
    bus.select_in = 1'b1;
    wait_cyc(8);
  endtask

  task automatic xfer(input logic [W-1:0] w, input int nbits, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi_in = w[W-1-i];
      wait_cyc(HALF);
      bus.sck_in = 1'b1;
      r = {r[30:0], bus.miso_out};
      wait_cyc(HALF);
      bus.sck_in = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_miso"},     32'(bus.miso_out),        32'h0);
    check({pfx, "_tx_ready"}, 32'(bus.tx_ready_out),    32'h1);
    check({pfx, "_rx_data"},  32'(bus.rx_data_out),     32'h0);
    check({pfx, "_rx_valid"}, 32'(bus.rx_valid_out),    32'h0);
    check({pfx, "_busy"},     32'(bus.busy_out),        32'h0);
    check({pfx, "_underrun"}, 32'(bus.tx_underrun_out), 32'h0);
  endtask

  initial begin
    logic [W-1:0] e1, e2, dummy, rw, tw;
    logic [31:0]  r1, r2;
    int           p0;
    logic         do_load;

    bus.select_in  = 1'b1;
    bus.sck_in     = 1'b0;
    bus.mosi_in    = 1'b0;
    bus.tx_data_in = '0;
    bus.tx_load_in = 1'b0;
    m_full = 1'b0; m_buf = '0; m_ur = 1'b0;
    rst = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(2);
    check_reset_outputs("reset");

    // Single word with a loaded buffer
    load(8'hA5);
    check("a5_ready_low", 32'(bus.tx_ready_out), 32'h0);
    p0 = vld_pulses;
    sel_low(e1);
    wait_cyc(4);
    check("a5_busy", 32'(bus.busy_out), 32'h1);
    xfer(8'h3C, W, r1);
    m_word_start(dummy);
    sel_high();
    check("a5_miso_model", r1, 32'(e1));
    check("a5_miso", r1, 32'hA5);
    check("a5_rx_data", 32'(bus.rx_data_out), 32'h3C);
    check("a5_pulses", 32'(vld_pulses - p0), 32'd1);
    check("a5_tx_ready", 32'(bus.tx_ready_out), 32'h1);
    check("a5_busy_idle", 32'(bus.busy_out), 32'h0);
    check("a5_underrun", 32'(bus.tx_underrun_out), 32'(exp_ur()));

    // Two words in one window; a load while full is ignored
    load(8'h11);
    load(8'h99);
    check("two_ready_low", 32'(bus.tx_ready_out), 32'h0);
    rx_q.delete();
    p0 = vld_pulses;
    sel_low(e1);
    fork
      xfer(8'hF0, W, r1);
      begin
        int k;
        for (k = 0; k < 40 && bus.tx_ready_out !== 1'b1; k++) @(negedge clk);
        check("two_ready_rise", 32'(bus.tx_ready_out), 32'h1);
        load(8'h22);
      end
    join
    m_word_start(e2);
    xfer(8'h0F, W, r2);
    m_word_start(dummy);
    sel_high();
    check("two_miso0", r1, 32'h11);
    check("two_miso1", r2, 32'h22);
    check("two_miso1_model", r2, 32'(e2));
    check("two_pulses", 32'(vld_pulses - p0), 32'd2);
    check("two_rxq_size", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check("two_rx0", 32'(rx_q[0]), 32'hF0);
      check("two_rx1", 32'(rx_q[1]), 32'h0F);
    end

    // Abort after 5 bits, then a full word
    p0 = vld_pulses;
    sel_low(e1);
    xfer(8'hFF, 5, r1);
    sel_high();
    check("abort_pulses", 32'(vld_pulses - p0), 32'd0);
    check("abort_rx_held", 32'(bus.rx_data_out), 32'h0F);
    load(8'h6B);
    sel_low(e1);
    xfer(8'h81, W, r1);
    m_word_start(dummy);
    sel_high();
    check("after_abort_rx", 32'(bus.rx_data_out), 32'h81);
    check("after_abort_pulses", 32'(vld_pulses - p0), 32'd1);
    check("after_abort_miso", r1, 32'(e1));

    // Empty buffer: zeros out, underrun until the next load
    sel_low(e1);
    xfer(8'h42, W, r1);
    m_word_start(dummy);
    sel_high();
    check("empty_miso", r1, 32'h0);
    check("empty_underrun", 32'(bus.tx_underrun_out), 32'(exp_ur()));
    wait_cyc(3);
    check("empty_underrun_held", 32'(bus.tx_underrun_out), 32'(exp_ur()));
    load(8'hC3);
    wait_cyc(1);
    check("load_clears_underrun", 32'(bus.tx_underrun_out), 32'h0);

    // Reset in the middle of a transfer
    sel_low(e1);
    load(8'h77);
    xfer(8'hAA, 4, r1);
    @(negedge clk);
    rst = 1'b1;
    bus.select_in = 1'b1;
    bus.mosi_in = 1'b0;
    @(negedge clk);
    m_full = 1'b0; m_ur = 1'b0;
    check_reset_outputs("midreset");
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(4);
    p0 = vld_pulses;
    load(8'h3D);
    sel_low(e1);
    xfer(8'h5A, W, r1);
    m_word_start(dummy);
    sel_high();
    check("post_reset_rx", 32'(bus.rx_data_out), 32'h5A);
    check("post_reset_miso", r1, 32'h3D);
    check("post_reset_pulses", 32'(vld_pulses - p0), 32'd1);

    // Randomized single-word windows
    for (int n = 0; n < 8; n++) begin
      do_load = 1'($urandom_range(0, 1));
      tw = W'($urandom);
      rw = W'($urandom);
      if (do_load) load(tw);
      p0 = vld_pulses;
      sel_low(e1);
      xfer(rw, W, r1);
      m_word_start(dummy);
      sel_high();
      check($sformatf("rnd%0d_miso", n), r1, 32'(e1));
      check($sformatf("rnd%0d_rx", n), 32'(bus.rx_data_out), 32'(rw));
      check($sformatf("rnd%0d_pulses", n), 32'(vld_pulses - p0), 32'd1);
      check($sformatf("rnd%0d_ready", n), 32'(bus.tx_ready_out), 32'(!m_full));
      check($sformatf("rnd%0d_underrun", n), 32'(bus.tx_underrun_out), 32'(exp_ur()));
    end

    check("rx_valid_one_cycle", 32'(vld_cycles), 32'(vld_pulses));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bits per SPI word (range 2..32).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on select_in, sck_in and mosi_in (range 2..3).
REQ-003 clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 select_in  input  1  SPI chip select, active low, asynchronous to clk_in.
REQ-006 sck_in  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk_in.
REQ-007 mosi_in  input  1  serial data from the master, MSB first.
REQ-008 miso_out  output  1  serial data to the master, MSB first.
REQ-009 tx_data_in  input  WIDTH  next word to transmit.
REQ-010 tx_load_in  input  1  write strobe for tx_data_in; accepted only while tx_ready_out=1.
REQ-011 tx_ready_out  output  1  high while the one-word tx buffer is empty.
REQ-012 rx_data_out  output  WIDTH  last completely received word; held until the next word completes.
REQ-013 rx_valid_out  output  1  one-cycle pulse when rx_data_out updates.
REQ-014 busy_out  output  1  high while the block is in S_ACTIVE.
REQ-015 tx_underrun_out  output  1  sticky underrun flag (see Configuration).

Function
REQ-016 Each async input SHALL pass through SYNC_STAGES flops, and sck edges SHALL be detected by comparing the synchronized sck with a one-cycle-delayed copy.
REQ-017 Legal operation SHALL require an f(clk_in) of at least 4x f(sck_in); behaviour outside this limit is undefined.
REQ-018 States SHALL be S_IDLE and S_ACTIVE: S_IDLE->S_ACTIVE on synchronized select falling, S_ACTIVE->S_IDLE on synchronized select high.
REQ-019 On entry to S_ACTIVE, the bit counter SHALL clear, the tx shift register SHALL load the tx buffer (or all zeros if the buffer is empty), and miso_out SHALL drive the shift register MSB in the same cycle.
REQ-020 On each detected sck rise in S_ACTIVE, synchronized mosi SHALL shift into the rx shift register LSB and the bit counter SHALL increment.
REQ-021 On the sck rise that brings the counter to WIDTH, the counter SHALL wrap to 0, and rx_data_out SHALL update and rx_valid_out SHALL pulse on the next clk_in cycle.
REQ-022 On each detected sck fall in S_ACTIVE, the tx shift register SHALL shift left and miso_out SHALL present the next bit; if the counter is 0 (word boundary), it SHALL instead reload from the tx buffer (zeros if empty).
REQ-023 Each load of the tx shift register from a full buffer SHALL empty the buffer, so tx_ready_out rises on the following cycle.
REQ-024 If tx_load_in and a buffer consume occur in the same cycle, the consume SHALL see the pre-load state and the new data SHALL remain in the buffer.
REQ-025 tx_load_in while tx_ready_out=0 SHALL be ignored, leaving the buffer unchanged.
REQ-026 Select deasserted mid-word SHALL abort: counter cleared, no rx_valid_out pulse, rx_data_out unchanged, and the tx buffer not consumed.
REQ-027 In S_IDLE, miso_out SHALL be 0 and sck edges SHALL be ignored.

Reset
REQ-028 Reset SHALL force S_IDLE, clear the counter, shift registers and synchronizers (select synchronizer preset to 1), and empty the tx buffer.
REQ-029 Reset values SHALL be: miso_out=0, tx_ready_out=1, rx_data_out=0, rx_valid_out=0, busy_out=0, tx_underrun_out=0.
REQ-030 Reset asserted mid-transfer SHALL take effect on the next clk_in edge, and the block SHALL wait for a fresh select falling edge before accepting data.

Configuration
REQ-031 With SPI_SLAVE_UNDERRUN_EN defined, tx_underrun_out SHALL set when a word starts (REQ-019 or REQ-022) with an empty tx buffer, and SHALL clear only on reset or on an accepted tx_load_in.
REQ-032 Without SPI_SLAVE_UNDERRUN_EN, tx_underrun_out SHALL be constant 0 and no underrun logic SHALL be instantiated.

Verification
REQ-033 Load 0xA5, then the master sends 0x3C with select low for 8 sck cycles -> master reads 0xA5 on MISO; rx_data_out=0x3C; one rx_valid_out pulse; tx_ready_out=1.
REQ-034 Load 0x11, then 0x22 once tx_ready_out rises; send 0xF0,0x0F in one select window -> MISO 0x11,0x22; two rx_valid pulses with rx_data 0xF0 then 0x0F.
REQ-035 Drop select after 5 bits of 0xFF -> no rx_valid_out pulse; rx_data_out keeps its prior value; the next full word 0x81 is received correctly.
REQ-036 Send a word with the tx buffer empty -> MISO 0x00; with the macro, tx_underrun_out=1 until the next load; without it, tx_underrun_out stays 0.
REQ-037 Assert reset_in at bit 4 of a transfer -> all outputs at their REQ-029 values next cycle; the next select window transfers 0x5A correctly.
